// File: rtl/lau_pkg.sv
// Shared types for the arithmetic unit blocks: implementation speed selector
// and the multiply-accumulate sequencing states.
package lau_pkg;

    typedef enum logic {
        FAST,
        SLOW
    } speed_e;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        FULL
    } mac_state_e;

endpackage

// File: rtl/MulAddSgn.sv
// Combinational signed multiply-add, P = X*Y + A, wrapping modulo 2^widthA.
// Both speed variants produce identical results; they differ in structure only.
module MulAddSgn
    import lau_pkg::*;
#(
    parameter int unsigned widthX = 8,
    parameter int unsigned widthY = 8,
    parameter int unsigned widthA = 20,
    parameter speed_e      speed  = FAST
) (
    input  logic [widthX-1:0] x,
    input  logic [widthY-1:0] y,
    input  logic [widthA-1:0] a,
    output logic [widthA-1:0] p
);

    localparam int unsigned widthP = widthX + widthY;

    generate
        if (speed == FAST) begin : g_fast
            // Full-precision product, then sign-extend and add
            logic signed [widthP-1:0] prod;
            assign prod = widthP'($signed(x)) * widthP'($signed(y));
            assign p    = widthA'(prod) + a;
        end else begin : g_slow
            // Multiply directly at accumulator width; low bits are identical
            logic signed [widthA-1:0] xe;
            logic signed [widthA-1:0] ye;
            assign xe = widthA'($signed(x));
            assign ye = widthA'($signed(y));
            assign p  = (xe * ye) + a;
        end
    endgenerate

endmodule

// File: rtl/mul_acc_sgn.sv
// Streaming signed multiply-accumulate: sums X*Y over a vector (closed by
// in_last) on top of a per-vector bias and emits one registered result.
module mul_acc_sgn
    import lau_pkg::*;
#(
    parameter int unsigned widthX = 8,
    parameter int unsigned widthY = 8,
    parameter int unsigned widthA = 20,
    parameter int unsigned widthC = 8,
    parameter speed_e      speed  = FAST
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [widthX-1:0] in_x,
    input  logic [widthY-1:0] in_y,
    input  logic [widthA-1:0] in_bias,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [widthA-1:0] out_acc,
    output logic [widthC-1:0] out_cnt
);

    mac_state_e        state_q, state_d;
    logic [widthA-1:0] acc_q, acc_d;
    logic [widthC-1:0] cnt_q, cnt_d;
    logic              out_valid_d;
    logic [widthA-1:0] out_acc_d;
    logic [widthC-1:0] out_cnt_d;

    logic              fire;
    logic              first_beat;
    logic [widthA-1:0] augend;
    logic [widthA-1:0] sum;
    logic [widthC-1:0] cnt_next;

    // Only path from an input straight to an output
    assign in_ready   = (state_q != FULL) | out_ready;
    assign fire       = in_valid & in_ready;
    assign first_beat = (state_q == IDLE) || (state_q == FULL);
    assign augend     = first_beat ? in_bias : acc_q;
    assign cnt_next   = first_beat ? widthC'(1)
                      : ((cnt_q == '1) ? cnt_q : cnt_q + widthC'(1));

    MulAddSgn #(
        .widthX(widthX),
        .widthY(widthY),
        .widthA(widthA),
        .speed (speed)
    ) u_mul_add (
        .x(in_x),
        .y(in_y),
        .a(augend),
        .p(sum)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_valid <= out_valid_d;
            out_acc   <= out_acc_d;
            out_cnt   <= out_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid;
        out_acc_d   = out_acc;
        out_cnt_d   = out_cnt;

        case (state_q)
            IDLE, ACC: begin
                if (fire) begin
                    if (in_last) begin
                        out_acc_d   = sum;
                        out_cnt_d   = cnt_next;
                        out_valid_d = 1'b1;
                        state_d     = FULL;
                    end else begin
                        acc_d   = sum;
                        cnt_d   = cnt_next;
                        state_d = ACC;
                    end
                end
            end
            FULL: begin
                // Result leaves on out_ready; a same-cycle beat starts the next vector
                if (out_ready) begin
                    if (fire && in_last) begin
                        out_acc_d = sum;
                        out_cnt_d = cnt_next;
                    end else if (fire) begin
                        acc_d       = sum;
                        cnt_d       = cnt_next;
                        out_valid_d = 1'b0;
                        state_d     = ACC;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_acc_sgn.sv
// Directed self-checking bench for mul_acc_sgn (8x8 operands, 20-bit accumulator).
module tb_mul_acc_sgn;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_y;
    logic [19:0] in_bias;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_acc;
    logic [7:0]  out_cnt;

    int checks;
    int errors;

    mul_acc_sgn #(
        .widthX(8),
        .widthY(8),
        .widthA(20),
        .widthC(8)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .in_bias  (in_bias),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc),
        .out_cnt  (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [19:0] bias;
        logic [19:0] exp_acc;
        logic [7:0]  exp_cnt;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [7:0] x, input logic [7:0] y,
                        input logic [19:0] bias, input logic last);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_bias  = bias;
        in_last  = last;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        checks = 0;
        errors = 0;

        // Single-beat vectors issued back to back with out_ready held high
        vecs[0] = '{8'h80, 8'h80, 20'hFFFFF, 20'h03FFF, 8'd1};
        vecs[1] = '{8'h01, 8'h01, 20'h7FFFF, 20'h80000, 8'd1};
        vecs[2] = '{8'h07, 8'hFD, 20'd100,   20'h0004F, 8'd1};
        vecs[3] = '{8'hFF, 8'h7F, 20'h00000, 20'hFFF81, 8'd1};
        vecs[4] = '{8'h7F, 8'h7F, 20'h80000, 20'h83F01, 8'd1};
        vecs[5] = '{8'h00, 8'hFB, 20'hFFFFF, 20'hFFFFF, 8'd1};
        vecs[6] = '{8'h80, 8'h7F, 20'h00000, 20'hFC080, 8'd1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_bias   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_acc",   32'(out_acc),   32'd0);
        chk("reset out_cnt",   32'(out_cnt),   32'd0);
        chk("reset in_ready",  32'(in_ready),  32'd1);

        // Basic two-beat vector; bias on the second beat must be ignored
        out_ready = 1'b1;
        beat(8'd3, 8'd4, 20'd0, 1'b0);
        tick();
        chk("basic mid out_valid", 32'(out_valid), 32'd0);
        beat(8'hFE, 8'd5, 20'd999, 1'b1);
        tick();
        chk("basic out_valid", 32'(out_valid), 32'd1);
        chk("basic out_acc",   32'(out_acc),   32'd2);
        chk("basic out_cnt",   32'(out_cnt),   32'd2);
        idle_in();
        tick();
        chk("basic drained", 32'(out_valid), 32'd0);

        for (int i = 0; i < 7; i++) begin
            beat(vecs[i].x, vecs[i].y, vecs[i].bias, 1'b1);
            tick();
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d out_acc", i),   32'(out_acc),   32'(vecs[i].exp_acc));
            chk($sformatf("vec%0d out_cnt", i),   32'(out_cnt),   32'(vecs[i].exp_cnt));
        end
        idle_in();
        tick();
        chk("table drained", 32'(out_valid), 32'd0);

        // Backpressure: result 4*4+1=17 held while downstream stalls
        out_ready = 1'b0;
        beat(8'd4, 8'd4, 20'd1, 1'b1);
        tick();
        beat(8'd9, 8'd9, 20'd0, 1'b1);
        #1;
        chk("bp in_ready low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp hold out_valid", 32'(out_valid), 32'd1);
            chk("bp hold out_acc",   32'(out_acc),   32'd17);
            chk("bp hold out_cnt",   32'(out_cnt),   32'd1);
        end
        out_ready = 1'b1;
        beat(8'd2, 8'd3, 20'd1, 1'b1);
        #1;
        chk("bp in_ready follows", 32'(in_ready), 32'd1);
        tick();
        chk("bp reload out_valid", 32'(out_valid), 32'd1);
        chk("bp reload out_acc",   32'(out_acc),   32'd7);
        chk("bp reload out_cnt",   32'(out_cnt),   32'd1);

        // Pop from FULL while a non-last beat starts a new vector: 10+4+1=15
        beat(8'd2, 8'd2, 20'd10, 1'b0);
        tick();
        chk("restart out_valid", 32'(out_valid), 32'd0);
        beat(8'd1, 8'd1, 20'd500, 1'b1);
        tick();
        chk("restart out_acc", 32'(out_acc), 32'd15);
        chk("restart out_cnt", 32'(out_cnt), 32'd2);

        // in_valid gap mid-vector: 5 + 2*2 + 3*3 = 18
        beat(8'd2, 8'd2, 20'd5, 1'b0);
        tick();
        idle_in();
        tick();
        tick();
        tick();
        chk("gap out_valid", 32'(out_valid), 32'd0);
        beat(8'd3, 8'd3, 20'd0, 1'b1);
        tick();
        chk("gap out_acc", 32'(out_acc), 32'd18);
        chk("gap out_cnt", 32'(out_cnt), 32'd2);
        idle_in();
        tick();

        // Counter saturation over 300 beats
        for (int i = 0; i < 300; i++) begin
            beat(8'd1, 8'd1, 20'd0, (i == 299));
            tick();
        end
        chk("sat out_valid", 32'(out_valid), 32'd1);
        chk("sat out_acc",   32'(out_acc),   32'd300);
        chk("sat out_cnt",   32'(out_cnt),   32'd255);
        idle_in();
        tick();

        // Reset mid-vector discards the partial sum
        beat(8'd5, 8'd5, 20'd0, 1'b0);
        tick();
        tick();
        idle_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst mid out_valid", 32'(out_valid), 32'd0);
        beat(8'd1, 8'd2, 20'd0, 1'b1);
        tick();
        chk("rst mid out_acc", 32'(out_acc), 32'd2);
        chk("rst mid out_cnt", 32'(out_cnt), 32'd1);

        // Reset while a result is pending
        out_ready = 1'b0;
        idle_in();
        tick();
        chk("rst full pending", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst full out_valid", 32'(out_valid), 32'd0);
        chk("rst full in_ready",  32'(in_ready),  32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
